// File: rtl/error_metric_accumulator.sv
// Error metric accumulator: compares an 8x8 approximate multiplier against the
// exact product over a run of N_SAMPLES triples and keeps ED statistics.
module error_metric_accumulator #(
   parameter int N_SAMPLES = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  op_a,
   input  logic [7:0]  op_b,
   input  logic [15:0] p_approx,
   output logic        busy,
   output logic        done,
   output logic [16:0] sample_cnt,
   output logic [16:0] err_cnt,
   output logic [31:0] ed_sum,
   output logic [15:0] ed_max,
   output logic [7:0]  worst_a,
   output logic [7:0]  worst_b
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [16:0] LAST_IDX = 17'(N_SAMPLES - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic        accept_s;
   logic        in_ready_r;
   logic        busy_r;
   logic        done_r;

   logic        s1_valid_r;
   logic [7:0]  s1_a_r;
   logic [7:0]  s1_b_r;
   logic [15:0] s1_p_r;
   logic        s2_valid_r;
   logic [7:0]  s2_a_r;
   logic [7:0]  s2_b_r;
   logic [15:0] s2_ed_r;
   logic [15:0] exact_s;
   logic [15:0] ed_s;

   logic [16:0] sample_cnt_r;
   logic [16:0] err_cnt_r;
   logic [31:0] ed_sum_r;
   logic [15:0] ed_max_r;
   logic [7:0]  worst_a_r;
   logic [7:0]  worst_b_r;

   // An abort cycle never transfers a triple, even with in_valid high.
   assign accept_s = in_valid & in_ready_r & ~start;

   // Next-state logic; start from any state restarts the run.
   always_comb begin
      state_nxt_s = state_r;
      if (start) begin
         state_nxt_s = RUN;
      end else begin
         case (state_r)
            IDLE:  state_nxt_s = IDLE;
            RUN: begin
               if (accept_s && (sample_cnt_r == LAST_IDX)) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            // Stage 1 empty with stage 2 full means the last sample lands now.
            DRAIN: begin
               if (s2_valid_r && !s1_valid_r) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = DRAIN;
               end
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register with status flags registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s == RUN);
         busy_r     <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
         done_r     <= (state_nxt_s == DONE);
      end
   end

   // Exact product and absolute error distance for the stage-1 sample.
   always_comb begin
      exact_s = 16'd0;
      ed_s    = 16'd0;
      exact_s = s1_a_r * s1_b_r;
      if (exact_s >= s1_p_r) begin
         ed_s = exact_s - s1_p_r;
      end else begin
         ed_s = s1_p_r - exact_s;
      end
   end

   // Two-stage sample pipeline: capture, then registered ED.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= 8'd0;
         s1_b_r     <= 8'd0;
         s1_p_r     <= 16'd0;
         s2_valid_r <= 1'b0;
         s2_a_r     <= 8'd0;
         s2_b_r     <= 8'd0;
         s2_ed_r    <= 16'd0;
      end else begin
         s1_valid_r <= accept_s;
         s2_valid_r <= s1_valid_r & ~start;
         if (accept_s) begin
            s1_a_r <= op_a;
            s1_b_r <= op_b;
            s1_p_r <= p_approx;
         end
         if (s1_valid_r) begin
            s2_a_r  <= s1_a_r;
            s2_b_r  <= s1_b_r;
            s2_ed_r <= ed_s;
         end
      end
   end

   // Run statistics; widths are sized so a full run cannot wrap.
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         sample_cnt_r <= 17'd0;
         err_cnt_r    <= 17'd0;
         ed_sum_r     <= 32'd0;
         ed_max_r     <= 16'd0;
         worst_a_r    <= 8'd0;
         worst_b_r    <= 8'd0;
      end else begin
         if (accept_s) begin
            sample_cnt_r <= sample_cnt_r + 17'd1;
         end
         if (s2_valid_r) begin
            ed_sum_r <= ed_sum_r + {16'd0, s2_ed_r};
            if (s2_ed_r != 16'd0) begin
               err_cnt_r <= err_cnt_r + 17'd1;
            end
            // Strictly greater: a tie keeps the earlier worst case.
            if (s2_ed_r > ed_max_r) begin
               ed_max_r  <= s2_ed_r;
               worst_a_r <= s2_a_r;
               worst_b_r <= s2_b_r;
            end
         end
      end
   end

   assign in_ready   = in_ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign sample_cnt = sample_cnt_r;
   assign err_cnt    = err_cnt_r;
   assign ed_sum     = ed_sum_r;
   assign ed_max     = ed_max_r;
   assign worst_a    = worst_a_r;
   assign worst_b    = worst_b_r;

endmodule

// File: tb/tb_error_metric_accumulator.sv
// Directed bench: four accumulator instances (N = 3, 2, 4, 65536) sharing the
// sample bus, each started separately, with hand-computed expected statistics.
module tb_error_metric_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  start;
   logic        in_valid;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [15:0] p_approx;

   logic        in_ready [4];
   logic        busy [4];
   logic        done [4];
   logic [16:0] sample_cnt [4];
   logic [16:0] err_cnt [4];
   logic [31:0] ed_sum [4];
   logic [15:0] ed_max [4];
   logic [7:0]  worst_a [4];
   logic [7:0]  worst_b [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   error_metric_accumulator #(.N_SAMPLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid),
      .in_ready(in_ready[0]), .op_a(op_a), .op_b(op_b), .p_approx(p_approx),
      .busy(busy[0]), .done(done[0]), .sample_cnt(sample_cnt[0]),
      .err_cnt(err_cnt[0]), .ed_sum(ed_sum[0]), .ed_max(ed_max[0]),
      .worst_a(worst_a[0]), .worst_b(worst_b[0]));

   error_metric_accumulator #(.N_SAMPLES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid),
      .in_ready(in_ready[1]), .op_a(op_a), .op_b(op_b), .p_approx(p_approx),
      .busy(busy[1]), .done(done[1]), .sample_cnt(sample_cnt[1]),
      .err_cnt(err_cnt[1]), .ed_sum(ed_sum[1]), .ed_max(ed_max[1]),
      .worst_a(worst_a[1]), .worst_b(worst_b[1]));

   error_metric_accumulator #(.N_SAMPLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid),
      .in_ready(in_ready[2]), .op_a(op_a), .op_b(op_b), .p_approx(p_approx),
      .busy(busy[2]), .done(done[2]), .sample_cnt(sample_cnt[2]),
      .err_cnt(err_cnt[2]), .ed_sum(ed_sum[2]), .ed_max(ed_max[2]),
      .worst_a(worst_a[2]), .worst_b(worst_b[2]));

   error_metric_accumulator #(.N_SAMPLES(65536)) u_dutx (
      .clk(clk), .rst_n(rst_n), .start(start[3]), .in_valid(in_valid),
      .in_ready(in_ready[3]), .op_a(op_a), .op_b(op_b), .p_approx(p_approx),
      .busy(busy[3]), .done(done[3]), .sample_cnt(sample_cnt[3]),
      .err_cnt(err_cnt[3]), .ed_sum(ed_sum[3]), .ed_max(ed_max[3]),
      .worst_a(worst_a[3]), .worst_b(worst_b[3]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge; inputs are changed and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      op_a = a; op_b = b; p_approx = p; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input int idx);
      start[idx] = 1'b1;
      step();
      start = 4'd0;
   endtask

   task automatic check_stats(input string tag, input int idx, input int sc, input int ec,
                              input int sum, input int mx, input int wa, input int wb);
      check_eq({tag, ".sample_cnt"}, 32'(sample_cnt[idx]), 32'(sc));
      check_eq({tag, ".err_cnt"},    32'(err_cnt[idx]),    32'(ec));
      check_eq({tag, ".ed_sum"},     ed_sum[idx],          32'(sum));
      check_eq({tag, ".ed_max"},     32'(ed_max[idx]),     32'(mx));
      check_eq({tag, ".worst_a"},    32'(worst_a[idx]),    32'(wa));
      check_eq({tag, ".worst_b"},    32'(worst_b[idx]),    32'(wb));
   endtask

   initial begin
      int exp_err;
      int exp_sum;
      logic [15:0] exact;
      logic [15:0] papx;
      int ed;

      rst_n = 1'b0; start = 4'd0; in_valid = 1'b0;
      op_a = 8'd0; op_b = 8'd0; p_approx = 16'd0;
      step(); step();
      rst_n = 1'b1;
      check_eq("rst.in_ready", 32'(in_ready[0]), 32'd0);
      check_eq("rst.busy", 32'(busy[0]), 32'd0);
      check_eq("rst.done", 32'(done[0]), 32'd0);
      check_stats("rst", 0, 0, 0, 0, 0, 0, 0);

      // Exact products, N=3
      pulse_start(0);
      check_eq("exact.in_ready", 32'(in_ready[0]), 32'd1);
      check_eq("exact.busy", 32'(busy[0]), 32'd1);
      send(8'd3, 8'd5, 16'd15);
      send(8'd255, 8'd255, 16'd65025);
      send(8'd0, 8'd200, 16'd0);
      check_eq("exact.drain_ready", 32'(in_ready[0]), 32'd0);
      check_eq("exact.drain_busy", 32'(busy[0]), 32'd1);
      step();
      check_eq("exact.done_early", 32'(done[0]), 32'd0);
      step();
      check_eq("exact.done", 32'(done[0]), 32'd1);
      check_eq("exact.busy_off", 32'(busy[0]), 32'd0);
      check_stats("exact", 0, 3, 0, 0, 0, 0, 0);

      // Triples presented in DONE or IDLE must not be counted
      send(8'd9, 8'd9, 16'd0);
      step(); step();
      check_stats("ign_done", 0, 3, 0, 0, 0, 0, 0);
      check_eq("ign_idle.sample_cnt", 32'(sample_cnt[1]), 32'd0);

      // Errors, restart from DONE: ED 10, 100, 10
      pulse_start(0);
      check_stats("restart", 0, 0, 0, 0, 0, 0, 0);
      send(8'd10, 8'd10, 16'd90);
      send(8'd200, 8'd200, 16'd40100);
      send(8'd2, 8'd3, 16'd16);
      step(); step();
      check_eq("err.done", 32'(done[0]), 32'd1);
      check_stats("err", 0, 3, 3, 120, 100, 200, 200);

      // Gaps and a tie, N=2: ED 4 then ED 4
      pulse_start(1);
      send(8'd4, 8'd4, 16'd12);
      step(); step();
      check_eq("gap.in_ready", 32'(in_ready[1]), 32'd1);
      send(8'd2, 8'd8, 16'd20);
      step(); step();
      check_eq("gap.done", 32'(done[1]), 32'd1);
      check_stats("gap", 1, 2, 2, 8, 4, 4, 4);

      // Abort after two accepted samples (ED 5 each), N=4
      pulse_start(2);
      send(8'd1, 8'd1, 16'd6);
      send(8'd2, 8'd2, 16'd9);
      pulse_start(2);
      check_stats("abort_clr", 2, 0, 0, 0, 0, 0, 0);
      check_eq("abort.busy", 32'(busy[2]), 32'd1);
      step(); step();
      check_stats("abort_flight", 2, 0, 0, 0, 0, 0, 0);
      send(8'd10, 8'd20, 16'd190);
      send(8'd7, 8'd7, 16'd49);
      send(8'd15, 8'd15, 16'd230);
      send(8'd3, 8'd3, 16'd0);
      step(); step();
      check_eq("abort.done", 32'(done[2]), 32'd1);
      check_stats("abort", 2, 4, 3, 24, 10, 10, 20);

      // Reset mid-run, held low two cycles
      pulse_start(2);
      send(8'd5, 8'd5, 16'd0);
      send(8'd6, 8'd6, 16'd0);
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      check_eq("mrst.in_ready", 32'(in_ready[2]), 32'd0);
      check_eq("mrst.busy", 32'(busy[2]), 32'd0);
      check_eq("mrst.done", 32'(done[2]), 32'd0);
      check_stats("mrst", 2, 0, 0, 0, 0, 0, 0);
      check_eq("mrst.done0", 32'(done[0]), 32'd0);

      // Exhaustive sweep; approximate product clears the low nibble and sets bit 3
      exp_err = 0;
      exp_sum = 0;
      pulse_start(3);
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            exact = 16'(a * b);
            papx  = (exact & 16'hFFF0) | 16'h0008;
            ed    = int'(exact[3:0]) - 8;
            if (ed < 0) ed = -ed;
            if (ed != 0) exp_err++;
            exp_sum += ed;
            send(8'(a), 8'(b), papx);
            if (a == 128 && b == 0) begin
               check_eq("sweep.in_ready", 32'(in_ready[3]), 32'd1);
            end
         end
      end
      check_eq("sweep.drain", 32'(done[3]), 32'd0);
      step(); step();
      check_eq("sweep.done", 32'(done[3]), 32'd1);
      check_stats("sweep", 3, 65536, exp_err, exp_sum, 8, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/error_metric_accumulator.md
ERROR_METRIC_ACCUMULATOR -- requirements
Module: error_metric_accumulator

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 65536, samples per run; legal range 1..65536.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse: clear statistics, begin run.
REQ-005 SHALL have port in_valid  input  1  operand/product triple valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a triple this cycle.
REQ-007 SHALL have port op_a  input  8  multiplicand as driven into the 8-bit approximate multiplier.
REQ-008 SHALL have port op_b  input  8  multiplier operand, same pairing.
REQ-009 SHALL have port p_approx  input  16  approximate multiplier product for op_a, op_b.
REQ-010 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-011 SHALL have port done  output  1  high in DONE; statistics final.
REQ-012 SHALL have ports sample_cnt, err_cnt  output  17  accepted samples; samples with ED != 0.
REQ-013 SHALL have port ed_sum  output  32  sum of error distances.
REQ-014 SHALL have ports ed_max  output  16, worst_a, worst_b  output  8  largest ED and its operands.

Function
REQ-015 SHALL transfer a sample only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL compute exact = op_a*op_b (16-bit unsigned) and ED = |exact - p_approx| (16-bit unsigned; p_approx > exact allowed).
REQ-017 SHALL pipeline: capture at accept edge k, ED registered at k+1, accumulators/ed_max updated at k+2.
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-019 SHALL move IDLE->RUN or DONE->RUN on start, clearing sample_cnt, err_cnt, ed_sum, ed_max, worst_a, worst_b and pipeline valids at the same edge.
REQ-020 SHALL drive in_ready=1 only in RUN.
REQ-021 SHALL move RUN->DRAIN on the edge accepting sample N_SAMPLES (sample_cnt reaches N_SAMPLES).
REQ-022 SHALL move DRAIN->DONE on the edge where the last sample updates the accumulators (2 cycles after entering DRAIN).
REQ-023 SHALL hold all statistics and done=1 in DONE until start or reset.
REQ-024 SHALL, on start in RUN or DRAIN, abort: discard in-flight samples, clear statistics, remain/enter RUN.
REQ-025 SHALL increment sample_cnt at acceptance; err_cnt, ed_sum at k+2 when ED != 0 (ed_sum adds ED unconditionally).
REQ-026 SHALL update ed_max/worst_a/worst_b only when ED > ed_max strictly; ties keep the earliest sample.
REQ-027 SHALL never wrap: widths cover N_SAMPLES=65536 at ED=65535 (max ed_sum 4294901760); no saturation logic.
REQ-028 SHALL ignore in_valid outside RUN and ignore start while rst_n=0.
REQ-029 SHALL accept back-to-back samples at one per cycle with no bubbles.

Reset
REQ-030 SHALL, on rising edge with rst_n=0, force IDLE and zero every output and pipeline valid (in_ready=0, busy=0, done=0, all statistics 0).
REQ-031 SHALL apply reset identically mid-run, discarding all partial statistics.

Verification
REQ-032 SHALL cover reset: rst_n low 2 cycles from arbitrary RUN state -> all outputs 0, in_ready=0, state IDLE.
REQ-033 SHALL cover exact run, N_SAMPLES=3: (3,5,15),(255,255,65025),(0,200,0) -> sample_cnt=3, err_cnt=0, ed_sum=0, ed_max=0, done 2 cycles after 3rd accept.
REQ-034 SHALL cover errors, N_SAMPLES=3: (10,10,90),(200,200,40100),(2,3,16) -> err_cnt=3, ed_sum=120, ed_max=100, worst_a=200, worst_b=200.
REQ-035 SHALL cover gaps/ties, N_SAMPLES=2: in_valid pattern 1,0,0,1 with (4,4,12),(2,8,20) -> sample_cnt=2, ed_sum=8, ed_max=4, worst_a=4, worst_b=4 (tie keeps first).
REQ-036 SHALL cover abort: start pulsed after 2 of 4 samples accepted -> statistics cleared that edge, run completes after 4 further accepts, in-flight samples absent from ed_sum.
REQ-037 SHALL cover exhaustive sweep: all 65536 (a,b) with p_approx from the approximate multiplier -> sample_cnt=65536, err_cnt and ed_sum match a software model.
